// File: rtl/apb_requester_arbiter.sv
// rtl/apb_requester_arbiter.sv - two-requester round-robin arbiter driving one APB completer
//
// Purpose:
//   Shares a single APB completer port between two requesters. In IDLE it picks
//   a winner (round-robin on contention) and latches that requester's command
//   into the APB output registers. It then runs SETUP and ACCESS, and returns
//   the completion (or a timeout) to the winner as a one-cycle ready pulse.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   i_req_*             per-requester command (valid/write/address/write_data/strobe),
//                       requester n occupies slice n of each packed vector
//   o_req_ready         one-cycle completion pulse to the granted requester
//   o_req_status        00 OK, 10 SLVERR, 11 timeout (valid with o_req_ready)
//   o_req_read_data     read data (valid with o_req_ready on reads)
//   o_grant, o_busy     current owner (one-hot) and transfer-in-progress flag
//   o_p*, i_p*          APB master signals

module apb_requester_arbiter #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [1:0]                   i_req_valid,
  input  logic [1:0]                   i_req_write,
  input  logic [2*ADDRESS_WIDTH-1:0]   i_req_address,
  input  logic [2*DATA_WIDTH-1:0]      i_req_write_data,
  input  logic [2*(DATA_WIDTH/8)-1:0]  i_req_strobe,
  output logic [1:0]                   o_req_ready,
  output logic [1:0]                   o_req_status,
  output logic [DATA_WIDTH-1:0]        o_req_read_data,
  output logic [1:0]                   o_grant,
  output logic                         o_busy,
  output logic                         o_psel,
  output logic                         o_penable,
  output logic [ADDRESS_WIDTH-1:0]     o_paddr,
  output logic                         o_pwrite,
  output logic [DATA_WIDTH-1:0]        o_pwdata,
  output logic [DATA_WIDTH/8-1:0]      o_pstrb,
  input  logic                         i_pready,
  input  logic [DATA_WIDTH-1:0]        i_prdata,
  input  logic                         i_pslverr
);

  localparam int AW = ADDRESS_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int SW = DATA_WIDTH / 8;
  // Counter only needs to reach TIMEOUT_CYCLES-1; keep at least one bit so a
  // disabled timeout (0) still yields a legal vector.
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic            last_idx_q, last_idx_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic            pwrite_q, pwrite_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [SW-1:0]   pstrb_q, pstrb_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_idx;
  logic            win_write;
  logic            timeout_hit;
  logic            complete;

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_idx_d      = last_idx_q;
    paddr_d         = paddr_q;
    pwrite_d        = pwrite_q;
    pwdata_d        = pwdata_q;
    pstrb_d         = pstrb_q;
    cnt_d           = cnt_q;
    win_idx         = 1'b0;
    win_write       = 1'b0;
    timeout_hit     = 1'b0;
    complete        = 1'b0;
    o_req_ready     = 2'b00;
    o_req_status    = 2'b00;
    o_req_read_data = '0;

    case (state_q)
      ST_IDLE: begin
        if (|i_req_valid) begin
          // On contention the requester that did not win last time goes next.
          if (i_req_valid == 2'b11) win_idx = ~last_idx_q;
          else                      win_idx = i_req_valid[1];
          win_write = win_idx ? i_req_write[1] : i_req_write[0];
          grant_d   = win_idx ? 2'b10 : 2'b01;
          paddr_d   = win_idx ? i_req_address[2*AW-1:AW] : i_req_address[AW-1:0];
          pwrite_d  = win_write;
          pwdata_d  = win_idx ? i_req_write_data[2*DW-1:DW] : i_req_write_data[DW-1:0];
          pstrb_d   = !win_write ? '0 :
                      (win_idx ? i_req_strobe[2*SW-1:SW] : i_req_strobe[SW-1:0]);
          state_d   = ST_SETUP;
        end
      end

      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end

      ST_ACCESS: begin
        timeout_hit = TO_EN && (cnt_q == TO_LAST);
        if (i_pready) begin
          // A real response beats a timeout landing in the same cycle.
          complete        = 1'b1;
          o_req_ready     = grant_q;
          o_req_status    = {i_pslverr, 1'b0};
          o_req_read_data = pwrite_q ? '0 : i_prdata;
        end else if (timeout_hit) begin
          complete     = 1'b1;
          o_req_ready  = grant_q;
          o_req_status = 2'b11;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (complete) begin
          state_d    = ST_IDLE;
          last_idx_d = grant_q[1];
          grant_d    = 2'b00;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= 2'b00;
      last_idx_q <= 1'b1;
      paddr_q    <= '0;
      pwrite_q   <= 1'b0;
      pwdata_q   <= '0;
      pstrb_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_idx_q <= last_idx_d;
      paddr_q    <= paddr_d;
      pwrite_q   <= pwrite_d;
      pwdata_q   <= pwdata_d;
      pstrb_q    <= pstrb_d;
      cnt_q      <= cnt_d;
    end
  end

  assign o_psel    = (state_q != ST_IDLE);
  assign o_penable = (state_q == ST_ACCESS);
  assign o_busy    = (state_q != ST_IDLE);
  assign o_grant   = grant_q;
  assign o_paddr   = paddr_q;
  assign o_pwrite  = pwrite_q;
  assign o_pwdata  = pwdata_q;
  assign o_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// tb/tb_apb_requester_arbiter.sv - randomized bench for apb_requester_arbiter against a transaction model
module tb_apb_requester_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        i_req_valid = '0;
  logic [1:0]        i_req_write = '0;
  logic [2*AW-1:0]   i_req_address = '0;
  logic [2*DW-1:0]   i_req_write_data = '0;
  logic [2*SW-1:0]   i_req_strobe = '0;
  logic [1:0]        o_req_ready;
  logic [1:0]        o_req_status;
  logic [DW-1:0]     o_req_read_data;
  logic [1:0]        o_grant;
  logic              o_busy;
  logic              o_psel;
  logic              o_penable;
  logic [AW-1:0]     o_paddr;
  logic              o_pwrite;
  logic [DW-1:0]     o_pwdata;
  logic [SW-1:0]     o_pstrb;
  logic              i_pready = 1'b0;
  logic [DW-1:0]     i_prdata = '0;
  logic              i_pslverr = 1'b0;

  apb_requester_arbiter #(
    .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write),
    .i_req_address(i_req_address), .i_req_write_data(i_req_write_data),
    .i_req_strobe(i_req_strobe),
    .o_req_ready(o_req_ready), .o_req_status(o_req_status),
    .o_req_read_data(o_req_read_data), .o_grant(o_grant), .o_busy(o_busy),
    .o_psel(o_psel), .o_penable(o_penable), .o_paddr(o_paddr),
    .o_pwrite(o_pwrite), .o_pwdata(o_pwdata), .o_pstrb(o_pstrb),
    .i_pready(i_pready), .i_prdata(i_prdata), .i_pslverr(i_pslverr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Requester-side view: each requester has at most one outstanding command.
  bit            pend[2];
  bit            en_req[2];
  logic [AW-1:0] r_addr[2];
  logic          r_wr[2];
  logic [DW-1:0] r_wd[2];
  logic [SW-1:0] r_st[2];

  // Transaction model: which phase of the current transfer we are in, who owns
  // it, how many ACCESS cycles have elapsed, and the command on the bus.
  int            phase;      // 0 idle, 1 first bus cycle, 2 waiting for completion
  int            owner;
  int            last_owner;
  int            waited;
  logic [AW-1:0] m_addr;
  logic          m_wr;
  logic [DW-1:0] m_wd;
  logic [SW-1:0] m_st;

  task automatic model_reset();
    phase = 0; owner = 0; last_owner = 1; waited = 0;
    m_addr = '0; m_wr = 1'b0; m_wd = '0; m_st = '0;
    for (int r = 0; r < 2; r++) pend[r] = 1'b0;
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < 2; r++) begin
      if (!pend[r] && en_req[r] && $urandom_range(0, 2) != 0) begin
        pend[r]   = 1'b1;
        r_addr[r] = AW'($urandom);
        r_wr[r]   = 1'($urandom_range(0, 1));
        r_wd[r]   = $urandom;
        r_st[r]   = SW'($urandom_range(1, 15));
      end
      i_req_valid[r]               = pend[r];
      i_req_write[r]               = r_wr[r];
      i_req_address[r*AW +: AW]    = r_addr[r];
      i_req_write_data[r*DW +: DW] = r_wd[r];
      i_req_strobe[r*SW +: SW]     = r_st[r];
    end
    i_pready  = ($urandom_range(0, 2) == 0);
    i_prdata  = $urandom;
    i_pslverr = ($urandom_range(0, 3) == 0);
  endtask

  task automatic check_and_update();
    bit         done;
    logic [1:0] oh;
    logic [1:0] exp_status;
    logic [DW-1:0] exp_rdata;
    oh = (owner == 1) ? 2'b10 : 2'b01;
    done = 1'b0;
    exp_status = 2'b00;
    exp_rdata = '0;
    check_eq("paddr", o_paddr, m_addr);
    check_eq("pwrite", o_pwrite, m_wr);
    check_eq("pwdata", o_pwdata, m_wd);
    check_eq("pstrb", o_pstrb, m_st);
    if (phase == 2) begin
      if (i_pready) begin
        done = 1'b1;
        exp_status = {i_pslverr, 1'b0};
        exp_rdata = m_wr ? '0 : i_prdata;
      end else if (waited == TO - 1) begin
        done = 1'b1;
        exp_status = 2'b11;
      end
    end
    check_eq("psel", o_psel, phase != 0);
    check_eq("penable", o_penable, phase == 2);
    check_eq("busy", o_busy, phase != 0);
    check_eq("grant", o_grant, (phase != 0) ? oh : 2'b00);
    check_eq("ready", o_req_ready, done ? oh : 2'b00);
    check_eq("status", o_req_status, exp_status);
    check_eq("read_data", o_req_read_data, exp_rdata);

    case (phase)
      0: if (pend[0] || pend[1]) begin
        owner  = (pend[0] && pend[1]) ? 1 - last_owner : (pend[0] ? 0 : 1);
        m_addr = r_addr[owner];
        m_wr   = r_wr[owner];
        m_wd   = r_wd[owner];
        m_st   = r_wr[owner] ? r_st[owner] : '0;
        phase  = 1;
      end
      1: begin
        phase  = 2;
        waited = 0;
      end
      default: begin
        if (done) begin
          phase       = 0;
          last_owner  = owner;
          pend[owner] = 1'b0;
        end else begin
          waited++;
        end
      end
    endcase
  endtask

  task automatic run_cycle();
    @(posedge clk);
    #1;
    drive_inputs();
    #1;
    check_and_update();
  endtask

  task automatic zero_inputs();
    i_req_valid = '0; i_req_write = '0; i_req_address = '0;
    i_req_write_data = '0; i_req_strobe = '0;
    i_pready = 1'b0; i_prdata = '0; i_pslverr = 1'b0;
  endtask

  initial begin
    bit found;
    en_req[0] = 1'b1;
    en_req[1] = 1'b1;
    model_reset();
    zero_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_psel", o_psel, 1'b0);
    check_eq("rst_penable", o_penable, 1'b0);
    check_eq("rst_grant", o_grant, 2'b00);
    check_eq("rst_busy", o_busy, 1'b0);
    check_eq("rst_paddr", o_paddr, '0);
    check_eq("rst_pstrb", o_pstrb, '0);
    check_eq("rst_ready", o_req_ready, 2'b00);
    rst_n = 1'b1;

    for (int c = 0; c < 2000; c++) run_cycle();

    // Pull reset while a transfer is waiting in ACCESS.
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      if (phase == 2) found = 1'b1;
      else run_cycle();
    end
    check_eq("reset_wait_access", found, 1'b1);
    @(posedge clk);
    #1;
    zero_inputs();
    rst_n = 1'b0;
    #1;
    check_eq("midrst_psel", o_psel, 1'b0);
    check_eq("midrst_penable", o_penable, 1'b0);
    check_eq("midrst_grant", o_grant, 2'b00);
    check_eq("midrst_busy", o_busy, 1'b0);
    check_eq("midrst_ready", o_req_ready, 2'b00);
    check_eq("midrst_paddr", o_paddr, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Requester 1 alone after reset, then free-running contention again.
    en_req[0] = 1'b0;
    for (int c = 0; c < 20; c++) run_cycle();
    en_req[0] = 1'b1;
    for (int c = 0; c < 1500; c++) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
